// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID-stage read ports and the
// write-back register file. The master modport is the pipeline side; the slave modport is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              WB_regwrite;
    logic              WB_memtoreg;
    logic [ADDR_W-1:0] WB_writeaddr;
    logic [DATA_W-1:0] WB_aluresult;
    logic [DATA_W-1:0] WB_memreaddata;
    logic              stall;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  commit_cnt;

    modport master (
        output WB_regwrite, WB_memtoreg, WB_writeaddr, WB_aluresult, WB_memreaddata,
        output stall, rs_addr, rt_addr, dbg_addr,
        input  rs_data, rt_data, dbg_data, wb_data, commit_cnt
    );

    modport slave (
        input  WB_regwrite, WB_memtoreg, WB_writeaddr, WB_aluresult, WB_memreaddata,
        input  stall, rs_addr, rt_addr, dbg_addr,
        output rs_data, rt_data, dbg_data, wb_data, commit_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it, serves two
// bypassed read ports plus an unbypassed debug port, and counts committed writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] wb_sel;
    logic              commit;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;
    logic [DATA_W-1:0] dbg_rd;

    assign wb_sel = bus.WB_memtoreg ? bus.WB_memreaddata : bus.WB_aluresult;

    // rst_n is part of commit so a held reset also suppresses the read bypass.
    assign commit = rst_n & bus.WB_regwrite & ~bus.stall & (bus.WB_writeaddr != '0);

    always_comb begin
        rs_rd = '0;
        if (bus.rs_addr != '0) begin
            if (commit && (bus.rs_addr == bus.WB_writeaddr)) rs_rd = wb_sel;
            else                                             rs_rd = regs_q[bus.rs_addr];
        end
    end

    always_comb begin
        rt_rd = '0;
        if (bus.rt_addr != '0) begin
            if (commit && (bus.rt_addr == bus.WB_writeaddr)) rt_rd = wb_sel;
            else                                             rt_rd = regs_q[bus.rt_addr];
        end
    end

    always_comb begin
        dbg_rd = '0;
        if (bus.dbg_addr != '0) dbg_rd = regs_q[bus.dbg_addr];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            if (commit) regs_q[bus.WB_writeaddr] <= wb_sel;
            cnt_q <= cnt_d;
        end
    end

    assign bus.rs_data    = rs_rd;
    assign bus.rt_data    = rt_rd;
    assign bus.dbg_data   = dbg_rd;
    assign bus.wb_data    = wb_sel;
    assign bus.commit_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus a randomized run against an
// array-based reference model; a second 4-bit-counter instance exercises counter wrap.
module tb_wb_regfile;
    logic clk;
    logic rst_n;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Narrow-counter instance sees exactly the same traffic as the main one.
    assign bus4.WB_regwrite    = bus.WB_regwrite;
    assign bus4.WB_memtoreg    = bus.WB_memtoreg;
    assign bus4.WB_writeaddr   = bus.WB_writeaddr;
    assign bus4.WB_aluresult   = bus.WB_aluresult;
    assign bus4.WB_memreaddata = bus.WB_memreaddata;
    assign bus4.stall          = bus.stall;
    assign bus4.rs_addr        = bus.rs_addr;
    assign bus4.rt_addr        = bus.rt_addr;
    assign bus4.dbg_addr       = bus.dbg_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] mem, input logic st,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        bus.WB_regwrite    = we;
        bus.WB_memtoreg    = m2r;
        bus.WB_writeaddr   = wa;
        bus.WB_aluresult   = alu;
        bus.WB_memreaddata = mem;
        bus.stall          = st;
        bus.rs_addr        = ra;
        bus.rt_addr        = rb;
        bus.dbg_addr       = rd;
    endtask

    function automatic logic model_commit();
        return rst_n && bus.WB_regwrite && !bus.stall && (bus.WB_writeaddr != 5'd0);
    endfunction

    function automatic logic [31:0] model_wb();
        return bus.WB_memtoreg ? bus.WB_memreaddata : bus.WB_aluresult;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (model_commit() && a == bus.WB_writeaddr) return model_wb();
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcnt = 32'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rs"},   bus.rs_data,  model_read(bus.rs_addr));
        chk({tag, ".rt"},   bus.rt_data,  model_read(bus.rt_addr));
        chk({tag, ".dbg"},  bus.dbg_data, mregs[bus.dbg_addr]);
        chk({tag, ".wb"},   bus.wb_data,  model_wb());
        chk({tag, ".cnt"},  bus.commit_cnt, mcnt);
        chk({tag, ".cnt4"}, 32'(bus4.commit_cnt), {28'd0, mcnt[3:0]});
    endtask

    // Advance one rising edge, applying the spec rules to the model with the inputs held.
    task automatic step();
        logic        c;
        logic [31:0] v;
        c = model_commit();
        v = model_wb();
        @(posedge clk);
        if (c) begin
            mregs[bus.WB_writeaddr] = v;
            mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  wa, ra, rb, rd;
        logic [31:0] c0;

        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Test 1: all indices read zero while reset is held.
        #2;
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr  = 5'(i);
            bus.rt_addr  = 5'(31 - i);
            bus.dbg_addr = 5'(i);
            #1;
            chk("rst.rs",  bus.rs_data,  32'd0);
            chk("rst.rt",  bus.rt_data,  32'd0);
            chk("rst.dbg", bus.dbg_data, 32'd0);
        end
        chk("rst.cnt", bus.commit_cnt, 32'd0);
        // A pending write during reset must neither bypass nor commit.
        drive(1'b1, 1'b0, 5'd4, 32'h1111_2222, 32'd0, 1'b0, 5'd4, 5'd4, 5'd4);
        #1;
        chk("rst.nobypass", bus.rs_data, 32'd0);
        @(posedge clk); #1;
        chk("rst.nowrite", bus.dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();

        // Test 2: write-first bypass, debug port sees stored value only.
        drive(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd5, 5'd0, 5'd5);
        #1;
        chk("t2.bypass", bus.rs_data,  32'hDEAD_BEEF);
        chk("t2.dbgpre", bus.dbg_data, 32'd0);
        check_all("t2");
        step();
        bus.WB_regwrite = 1'b0;
        #1;
        chk("t2.dbgpost", bus.dbg_data,   32'hDEAD_BEEF);
        chk("t2.cnt",     bus.commit_cnt, 32'd1);

        // Test 3: memtoreg selects load data.
        drive(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 5'd7, 5'd7, 5'd7);
        #1;
        chk("t3.wb", bus.wb_data, 32'h1234_5678);
        check_all("t3");
        step();
        bus.WB_regwrite = 1'b0;
        #1;
        chk("t3.reg7", bus.dbg_data, 32'h1234_5678);
        chk("t3.cnt",  bus.commit_cnt, 32'd2);

        // Test 4: writes to r0 are dropped; stall blocks write, bypass and count.
        drive(1'b1, 1'b0, 5'd0, 32'hAAAA_5555, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t4.r0in", bus.rs_data, 32'd0);
        step();
        chk("t4.r0after", bus.rs_data,    32'd0);
        chk("t4.cnt",     bus.commit_cnt, 32'd2);
        drive(1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        #1;
        chk("t4.stallbyp", bus.rs_data, 32'd0);
        check_all("t4s");
        step();
        chk("t4.reg9",     bus.dbg_data,   32'd0);
        chk("t4.stallcnt", bus.commit_cnt, 32'd2);

        // Test 5: asynchronous reset between edges after writing r3.
        drive(1'b1, 1'b0, 5'd3, 32'h0000_0055, 32'h0, 1'b0, 5'd3, 5'd3, 5'd3);
        #1;
        step();
        bus.WB_regwrite = 1'b0;
        #1;
        chk("t5.reg3", bus.dbg_data, 32'h0000_0055);
        bus.WB_regwrite = 1'b1;
        bus.WB_writeaddr = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5.rstdbg", bus.dbg_data,   32'd0);
        chk("t5.rstrs",  bus.rs_data,    32'd0);
        chk("t5.rstcnt", bus.commit_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd6, 5'd0, 5'd6);
        #1;
        check_all("t5post");
        step();

        // Randomized traffic with read/write index collisions; r1..r3 biased to collide often.
        for (int n = 0; n < 600; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? wa : (($urandom_range(0, 1) == 0) ? ra : 5'($urandom));
            rd = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), wa, $urandom, $urandom,
                  1'($urandom_range(0, 5) == 0), ra, rb, rd);
            #1;
            check_all("rnd");
            step();
        end

        // Final sweep of stored state through the debug port.
        bus.WB_regwrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            #1;
            chk("sweep.dbg", bus.dbg_data, mregs[i]);
        end
        c0 = mcnt;
        chk("sweep.cnt", bus.commit_cnt, c0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
